// File: rtl/multi_reaction_timer.sv
// N-player reaction timer: LFSR-randomised pre-stimulus delay, then per-player
// BCD millisecond capture with false-start, timeout and winner tracking.
module multi_reaction_timer #(
  parameter int N_PLAYERS    = 2,
  parameter int CLK_PER_MS   = 100000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_EN      = 1,
  parameter int DELAY_BITS   = 11,
  parameter int TIMEOUT_MS   = 1000
) (
  input  logic                      i_CLK,
  input  logic                      i_RST_N,
  input  logic                      i_START,
  input  logic [N_PLAYERS-1:0]      i_STOP,
  output logic [1:0]                o_STATE,
  output logic                      o_STIMULUS,
  output logic [16*N_PLAYERS-1:0]   o_BCD,
  output logic [N_PLAYERS-1:0]      o_DONE,
  output logic [N_PLAYERS-1:0]      o_FAIL,
  output logic [N_PLAYERS-1:0]      o_TIMEOUT,
  output logic [2:0]                o_WINNER,
  output logic                      o_WINNER_VALID
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int DW = 14;
  localparam logic [15:0] TIMEOUT_BCD = {4'(TIMEOUT_MS / 1000), 4'((TIMEOUT_MS / 100) % 10),
                                         4'((TIMEOUT_MS / 10) % 10), 4'(TIMEOUT_MS % 10)};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ARMED  = 2'd2,
    S_RESULT = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [15:0]               lfsr_q, lfsr_d;
  logic [PW-1:0]             presc_q, presc_d;
  logic [DW-1:0]             delay_q, delay_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [16*N_PLAYERS-1:0]   bcd_q, bcd_d;
  logic [N_PLAYERS-1:0]      done_q, done_d;
  logic [N_PLAYERS-1:0]      fail_q, fail_d;
  logic [N_PLAYERS-1:0]      tmo_q, tmo_d;
  logic [2:0]                win_q, win_d;
  logic                      winv_q, winv_d;
  logic [15:0]               best_q, best_d;
  logic                      stim_q, stim_d;
  logic                      tick_s;
  logic [DW-1:0]             load_s;
  logic [N_PLAYERS-1:0]      cap_s;

  // Four-digit BCD increment that holds at 9999
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v == 16'h9999) begin
      r = v;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (c && (r[4*i +: 4] == 4'd9)) begin
          r[4*i +: 4] = 4'd0;
        end else if (c) begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end else begin
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick_s = (presc_q == PW'(CLK_PER_MS - 1));
  assign load_s = DW'(MIN_DELAY_MS) + ((RAND_EN != 0) ? DW'(lfsr_q[DELAY_BITS-1:0]) : DW'(0));

  // Next-state, capture, timeout and winner logic
  always_comb begin
    state_d = state_q;
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    presc_d = tick_s ? PW'(0) : presc_q + PW'(1);
    delay_d = delay_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = done_q;
    fail_d  = fail_q;
    tmo_d   = tmo_q;
    win_d   = win_q;
    winv_d  = winv_q;
    best_d  = best_q;
    cap_s   = {N_PLAYERS{1'b0}};
    case (state_q)
      S_IDLE, S_RESULT: begin
        presc_d = PW'(0);
        if (i_START) begin
          state_d = S_WAIT;
          delay_d = load_s;
          cnt_d   = 16'd0;
          bcd_d   = {(16*N_PLAYERS){1'b0}};
          done_d  = {N_PLAYERS{1'b0}};
          fail_d  = {N_PLAYERS{1'b0}};
          tmo_d   = {N_PLAYERS{1'b0}};
          win_d   = 3'd0;
          winv_d  = 1'b0;
          best_d  = 16'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_WAIT: begin
        delay_d = tick_s ? delay_q - DW'(1) : delay_q;
        fail_d  = fail_q | i_STOP;
        done_d  = done_q | i_STOP;
        if (&done_d) begin
          state_d = S_RESULT;
        end else if (tick_s && (delay_q == DW'(1))) begin
          state_d = S_ARMED;
          presc_d = PW'(0);
          cnt_d   = 16'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_ARMED: begin
        cnt_d = tick_s ? bcd_inc(cnt_q) : cnt_q;
        cap_s = i_STOP & ~done_q;
        // Ascending scan with strict compare: same-cycle ties keep the lowest index
        for (int p = 0; p < N_PLAYERS; p++) begin
          if (cap_s[p]) begin
            bcd_d[16*p +: 16] = cnt_q;
            if (!winv_d || (cnt_q < best_d)) begin
              win_d  = 3'(p);
              winv_d = 1'b1;
              best_d = cnt_q;
            end else begin
              win_d = win_d;
            end
          end else begin
            bcd_d[16*p +: 16] = bcd_d[16*p +: 16];
          end
        end
        done_d = done_q | cap_s;
        if (&done_d) begin
          state_d = S_RESULT;
        end else if (tick_s && (cnt_d == TIMEOUT_BCD)) begin
          state_d = S_RESULT;
          tmo_d   = ~done_d;
          for (int p = 0; p < N_PLAYERS; p++) begin
            if (!done_d[p]) begin
              bcd_d[16*p +: 16] = TIMEOUT_BCD;
            end else begin
              bcd_d[16*p +: 16] = bcd_d[16*p +: 16];
            end
          end
          done_d = {N_PLAYERS{1'b1}};
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    stim_d = (state_d == S_ARMED);
  end

  // State, LFSR and result registers
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q <= S_IDLE;
      lfsr_q  <= 16'hACE1;
      presc_q <= PW'(0);
      delay_q <= DW'(0);
      cnt_q   <= 16'd0;
      bcd_q   <= {(16*N_PLAYERS){1'b0}};
      done_q  <= {N_PLAYERS{1'b0}};
      fail_q  <= {N_PLAYERS{1'b0}};
      tmo_q   <= {N_PLAYERS{1'b0}};
      win_q   <= 3'd0;
      winv_q  <= 1'b0;
      best_q  <= 16'd0;
      stim_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      presc_q <= presc_d;
      delay_q <= delay_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
      win_q   <= win_d;
      winv_q  <= winv_d;
      best_q  <= best_d;
      stim_q  <= stim_d;
    end
  end

  assign o_STATE        = state_q;
  assign o_STIMULUS     = stim_q;
  assign o_BCD          = bcd_q;
  assign o_DONE         = done_q;
  assign o_FAIL         = fail_q;
  assign o_TIMEOUT      = tmo_q;
  assign o_WINNER       = win_q;
  assign o_WINNER_VALID = winv_q;

endmodule
